// File: rtl/fb_pkg.sv
// Shared framebuffer geometry, sync timing and pixel type for fb_pixel_sink.
package fb_pkg;
  localparam int H_VIS    = 160;
  localparam int V_VIS    = 120;
  localparam int H_TOT    = 200;
  localparam int V_TOT    = 130;
  localparam int HS_START = 168;
  localparam int HS_END   = 183;
  localparam int VS_START = 122;
  localparam int VS_END   = 123;
  localparam int ADDR_W   = 15;
  localparam int FB_DEPTH = H_VIS * V_VIS;

  typedef logic [2:0] pixel_t;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    pixel_t     colour;
  } wr_req_t;

  // row*160 + col as shift-and-add so no multiplier is built
  function automatic logic [ADDR_W-1:0] fb_addr(input logic [7:0] col, input logic [7:0] row);
    return (ADDR_W'(row) << 7) + (ADDR_W'(row) << 5) + ADDR_W'(col);
  endfunction
endpackage

// File: rtl/fb_pixel_sink_if.sv
// Write port and scan-out bundle of fb_pixel_sink.
// FB_STATS_EN adds the wr_count/drop_count counters to the bundle.
interface fb_pixel_sink_if;
  import fb_pkg::*;

  logic [7:0] x;
  logic [6:0] y;
  pixel_t     colour;
  logic       draw;
  pixel_t     pix_colour;
  logic       pix_active;
  logic       hsync;
  logic       vsync;
  logic       err_oob;
`ifdef FB_STATS_EN
  logic [15:0] wr_count;
  logic [15:0] drop_count;
`endif

  modport master (
    output x, y, colour, draw,
`ifdef FB_STATS_EN
    input  wr_count, drop_count,
`endif
    input  pix_colour, pix_active, hsync, vsync, err_oob
  );

  modport slave (
    input  x, y, colour, draw,
`ifdef FB_STATS_EN
    output wr_count, drop_count,
`endif
    output pix_colour, pix_active, hsync, vsync, err_oob
  );
endinterface

// File: rtl/fb_ram.sv
// Framebuffer store: one write port, one read-first synchronous read port, no reset.
module fb_ram
  import fb_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  pixel_t            wdata,
  input  logic [ADDR_W-1:0] raddr,
  output pixel_t            rdata
);
  pixel_t mem [FB_DEPTH];

  // both updates are non-blocking, so a same-address read returns the old word
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/fb_pixel_sink.sv
// 160x120x3 framebuffer with a free-running write port and a 200x130 raster scan-out.
// Define FB_STATS_EN to add saturating committed/dropped write counters.
module fb_pixel_sink
  import fb_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input logic            clk,
  input logic            rst,
  fb_pixel_sink_if.slave bus
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0]  div;
  logic [7:0]        hcount, vcount;
  logic              tick, visible, in_range, wr_en;
  logic              act_q, hs_q, vs_q;
  logic [ADDR_W-1:0] waddr, raddr;
  pixel_t            rdata;
  wr_req_t           req;

  assign req      = '{x: bus.x, y: bus.y, colour: bus.colour};
  assign in_range = (req.x < 8'(H_VIS)) && (req.y < 7'(V_VIS));
  assign wr_en    = rst && bus.draw && in_range;
  assign waddr    = fb_addr(req.x, {1'b0, req.y});
  assign tick     = (div == DIV_W'(CLK_DIV - 1));
  assign visible  = (hcount < 8'(H_VIS)) && (vcount < 8'(V_VIS));
  // blanking rows/columns would index past the array, so park the read at 0
  assign raddr    = visible ? fb_addr(hcount, vcount) : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      div    <= '0;
      hcount <= '0;
      vcount <= '0;
    end else if (tick) begin
      div <= '0;
      if (hcount == 8'(H_TOT - 1)) begin
        hcount <= '0;
        vcount <= (vcount == 8'(V_TOT - 1)) ? '0 : vcount + 8'd1;
      end else begin
        hcount <= hcount + 8'd1;
      end
    end else begin
      div <= div + 1'b1;
    end
  end

  // timing flags lag one clock to line up with the synchronous RAM read
  always_ff @(posedge clk) begin
    if (!rst) begin
      act_q       <= 1'b0;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      bus.err_oob <= 1'b0;
    end else begin
      act_q       <= visible;
      hs_q        <= !((hcount >= 8'(HS_START)) && (hcount <= 8'(HS_END)));
      vs_q        <= !((vcount >= 8'(VS_START)) && (vcount <= 8'(VS_END)));
      bus.err_oob <= bus.draw && !in_range;
    end
  end

  assign bus.pix_colour = act_q ? rdata : '0;
  assign bus.pix_active = act_q;
  assign bus.hsync      = hs_q;
  assign bus.vsync      = vs_q;

  fb_ram u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (waddr),
    .wdata (req.colour),
    .raddr (raddr),
    .rdata (rdata)
  );

`ifdef FB_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.wr_count   <= '0;
      bus.drop_count <= '0;
    end else begin
      if (wr_en && bus.wr_count != 16'hFFFF)
        bus.wr_count <= bus.wr_count + 16'd1;
      if (bus.draw && !in_range && bus.drop_count != 16'hFFFF)
        bus.drop_count <= bus.drop_count + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fb_pixel_sink.sv
// Bench for fb_pixel_sink: random and directed writes scored against a raster/array reference model.
`timescale 1ns/1ps
module tb_fb_pixel_sink;
  import fb_pkg::*;

  localparam int CLK_DIV = 2;
  localparam int FRAME   = 200 * 130 * CLK_DIV;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fb_pixel_sink_if bus ();
  fb_pixel_sink #(.CLK_DIV(CLK_DIV)) dut (.clk(clk), .rst(rst), .bus(bus));

  int     errors = 0;
  int     checks = 0;
  pixel_t mem   [19200];
  bit     known [19200];
  int     k;                      // clock edges since reset release
  int     n_wr, n_drop;
  int     bad;
  string  first_msg;
  int     hs_low, vs_low, act_hi, hs_fall, vs_fall;
  logic   hs_prev, vs_prev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic scan_chk(input string tag);
    checks++;
    assert (bad === 0) else begin
      errors++;
      $error("FAIL %s: got %0d bad cycles, expected 0; first %s", tag, bad, first_msg);
    end
  endtask

  task automatic clear_scan();
    bad = 0; hs_low = 0; vs_low = 0; act_hi = 0; hs_fall = 0; vs_fall = 0;
    hs_prev = 1'b1; vs_prev = 1'b1;
  endtask

  // Drive one request, take one edge, compare against the position implied by k.
  task automatic step(input bit wr, input int wx, input int wy, input pixel_t wc);
    int t, h, v, a;
    bit oob, eact, ehs, evs, colbad;
    pixel_t ecol;
    bus.draw = wr; bus.x = 8'(wx); bus.y = 7'(wy); bus.colour = wc;
    @(posedge clk); #1;
    t = k / CLK_DIV;
    h = t % 200;
    v = (t / 200) % 130;
    eact = (h < 160) && (v < 120);
    ehs  = !(h >= 168 && h <= 183);
    evs  = !(v >= 122 && v <= 123);
    oob  = (wx >= 160) || (wy >= 120);
    a    = eact ? v * 160 + h : 0;
    ecol = eact ? mem[a] : 3'b000;
    colbad = (eact && !known[a]) ? 1'b0 : (bus.pix_colour !== ecol);
    if (bus.pix_active !== eact || bus.hsync !== ehs || bus.vsync !== evs ||
        bus.err_oob !== (wr && oob) || colbad) begin
      if (bad == 0)
        first_msg = $sformatf("k=%0d h=%0d v=%0d col=%0d/%0d act=%0d/%0d hs=%0d/%0d vs=%0d/%0d err=%0d/%0d",
                              k, h, v, bus.pix_colour, ecol, bus.pix_active, eact,
                              bus.hsync, ehs, bus.vsync, evs, bus.err_oob, wr && oob);
      bad++;
    end
    if (!bus.hsync) hs_low++;
    if (!bus.vsync) vs_low++;
    if (bus.pix_active) act_hi++;
    if (hs_prev && !bus.hsync) hs_fall++;
    if (vs_prev && !bus.vsync) vs_fall++;
    hs_prev = bus.hsync;
    vs_prev = bus.vsync;
    // write lands after the read of this edge, matching read-first RAM behaviour
    if (wr && !oob) begin
      mem[wy * 160 + wx] = wc; known[wy * 160 + wx] = 1'b1; n_wr++;
    end
    if (wr && oob) n_drop++;
    k++;
  endtask

  task automatic rnd_step();
    step(1'($urandom_range(1, 0)), int'($urandom_range(175, 0)),
         int'($urandom_range(127, 20)), 3'($urandom_range(7, 0)));
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_pix_colour"}, 32'(bus.pix_colour), 0);
    chk({tag, "_pix_active"}, 32'(bus.pix_active), 0);
    chk({tag, "_hsync"}, 32'(bus.hsync), 1);
    chk({tag, "_vsync"}, 32'(bus.vsync), 1);
    chk({tag, "_err_oob"}, 32'(bus.err_oob), 0);
  endtask

  initial begin
    int p, kk;
    // reset with an out-of-range draw held: it must not raise err_oob
    bus.draw = 1'b1; bus.x = 8'd200; bus.y = 7'd0; bus.colour = 3'd7;
    repeat (3) @(posedge clk);
    #1;
    reset_vals("reset");
`ifdef FB_STATS_EN
    chk("reset_wr_count", 32'(bus.wr_count), 0);
    chk("reset_drop_count", 32'(bus.drop_count), 0);
`endif
    rst = 1'b1; k = 0; n_wr = 0; n_drop = 0; p = 0;
    clear_scan();

    // frame 0: prefill ahead of the scan, collide on (10,10), two drops, then random writes
    while (k < FRAME) begin
      kk = k;
      if (kk == 4021) begin
        step(1'b1, 10, 10, 3'b110);
        chk("collide_old_10_10", 32'(bus.pix_colour), 0);
      end else if (p < 19200) begin
        step(1'b1, p % 160, p / 160, (p == 3 * 160 + 5) ? 3'b101 : 3'b000);
        p++;
      end else if (p == 19200) begin
        step(1'b1, 160, 0, 3'b111);
        chk("err_oob_x160", 32'(bus.err_oob), 1);
        p++;
      end else if (p == 19201) begin
        step(1'b1, 0, 120, 3'b111);
        chk("err_oob_y120", 32'(bus.err_oob), 1);
`ifdef FB_STATS_EN
        chk("drop_count_2", 32'(bus.drop_count), 2);
`endif
        p++;
      end else begin
        rnd_step();
      end
      if (kk == 1210) chk("pix_5_3", 32'(bus.pix_colour), 32'b101);
      if (kk == 1212) chk("pix_6_3", 32'(bus.pix_colour), 0);
      if (kk == 1208) chk("pix_4_3", 32'(bus.pix_colour), 0);
    end
    scan_chk("frame0_scan");
    chk("hsync_low_clocks", 32'(hs_low), 32'(130 * 16 * CLK_DIV));
    chk("hsync_runs", 32'(hs_fall), 130);
    chk("vsync_low_clocks", 32'(vs_low), 32'(2 * 200 * CLK_DIV));
    chk("vsync_runs", 32'(vs_fall), 1);
    chk("active_clocks", 32'(act_hi), 32'(160 * 120 * CLK_DIV));
`ifdef FB_STATS_EN
    chk("wr_count_frame0", 32'(bus.wr_count), 32'(n_wr));
    chk("drop_count_frame0", 32'(bus.drop_count), 32'(n_drop));
`endif

    // frame 1: new (10,10) value visible, then reset while the scan sits at (90,60)
    clear_scan();
    while (k < FRAME + 2 * (60 * 200 + 90) + 1) begin
      kk = k;
      rnd_step();
      if (kk == FRAME + 4021) chk("collide_new_10_10", 32'(bus.pix_colour), 32'b110);
    end
    scan_chk("frame1_scan");
    rst = 1'b0;
    bus.draw = 1'b1; bus.x = 8'd5; bus.y = 7'd3; bus.colour = 3'b010;
    @(posedge clk); #1;
    reset_vals("midreset");
`ifdef FB_STATS_EN
    chk("midreset_wr_count", 32'(bus.wr_count), 0);
`endif
    bus.x = 8'd170; bus.y = 7'd0;
    @(posedge clk); #1;
    chk("midreset_err_oob_held", 32'(bus.err_oob), 0);

    // after release the raster restarts at (0,0) and earlier contents persist
    rst = 1'b1; k = 0; n_wr = 0; n_drop = 0;
    clear_scan();
    while (k < 12 * 200 * CLK_DIV) begin
      kk = k;
      step(1'b0, 0, 0, 3'b000);
      if (kk == 0) chk("restart_origin_active", 32'(bus.pix_active), 1);
      if (kk == 1210) chk("persist_5_3", 32'(bus.pix_colour), 32'b101);
      if (kk == 4020) chk("persist_10_10", 32'(bus.pix_colour), 32'b110);
    end
    scan_chk("post_reset_scan");

`ifdef FB_STATS_EN
    for (int i = 0; i < 70000; i++) step(1'b1, i % 160, (i / 160) % 120, 3'(i));
    chk("wr_count_saturated", 32'(bus.wr_count), 32'hFFFF);
    chk("drop_count_after_burst", 32'(bus.drop_count), 0);
`endif

    bus.draw = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
